// File: rtl/mapper_revlookup.sv
// Reverse translator for the CPU bank mapper: snoops bank-register writes into a shadow
// map and answers physical-to-CPU address lookups with a fixed 16-cycle linear scan.
module mapper_revlookup (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] cpuaddr_i,
  input  logic [7:0]  wdata_i,
  input  logic        rw_i,
  input  logic        cs_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [19:0] req_paddr_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic        resp_hit_o,
  output logic        resp_multi_o,
  output logic        resp_stale_o,
  output logic [15:0] resp_cpuaddr_o
);

  typedef enum logic [1:0] {StIdle, StScan, StResp} state_e;

  state_e      state_q, state_d;
  logic [7:0]  shadow_q [16];
  logic [7:0]  shadow_d [16];
  logic [19:0] paddr_q, paddr_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  win_q, win_d;
  logic        hit_q, hit_d;
  logic        multi_q, multi_d;
  logic        stale_q, stale_d;
  logic        snoop_wr;
  logic        match;

  // Only the low nibble selects a bank register.
  logic unused_cpuaddr;
  assign unused_cpuaddr = ^cpuaddr_i[15:4];

  // Power-up map of the mapper: banks 0..10 identity, 11..15 at the top of memory.
  function automatic logic [7:0] default_bank(input logic [3:0] i);
    return (i <= 4'd10) ? {4'h0, i} : {4'hF, i};
  endfunction

  assign snoop_wr = cs_i & ~rw_i;
  assign match    = (shadow_q[idx_q] == paddr_q[19:12]);

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    paddr_d  = paddr_q;
    idx_d    = idx_q;
    win_d    = win_q;
    hit_d    = hit_q;
    multi_d  = multi_q;
    stale_d  = stale_q;

    if (snoop_wr) begin
      shadow_d[cpuaddr_i[3:0]] = wdata_i;
    end

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          paddr_d = req_paddr_i;
          idx_d   = 4'd0;
          win_d   = 4'd0;
          hit_d   = 1'b0;
          multi_d = 1'b0;
          stale_d = snoop_wr;
          state_d = StScan;
        end
      end
      StScan: begin
        // Compare uses the pre-edge shadow value; a same-edge write only marks stale.
        if (match) begin
          if (!hit_q) begin
            hit_d = 1'b1;
            win_d = idx_q;
          end else begin
            multi_d = 1'b1;
          end
        end
        stale_d = stale_q | snoop_wr;
        if (idx_q == 4'd15) begin
          state_d = StResp;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      StResp: begin
        stale_d = stale_q | snoop_wr;
        if (resp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      paddr_q <= 20'h0;
      idx_q   <= 4'd0;
      win_q   <= 4'd0;
      hit_q   <= 1'b0;
      multi_q <= 1'b0;
      stale_q <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        shadow_q[i] <= default_bank(4'(i));
      end
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      paddr_q  <= paddr_d;
      idx_q    <= idx_d;
      win_q    <= win_d;
      hit_q    <= hit_d;
      multi_q  <= multi_d;
      stale_q  <= stale_d;
    end
  end

  assign req_ready_o    = (state_q == StIdle);
  assign resp_valid_o   = (state_q == StResp);
  assign resp_hit_o     = hit_q;
  assign resp_multi_o   = multi_q;
  assign resp_stale_o   = stale_q;
  assign resp_cpuaddr_o = hit_q ? {win_q, paddr_q[11:0]} : 16'h0000;

endmodule

// File: tb/tb_mapper_revlookup.sv
// Bench for mapper_revlookup: directed lookups with literal expectations plus a random
// phase, all checked every cycle against a transaction-level model of the shadow map.
module tb_mapper_revlookup;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpuaddr;
  logic [7:0]  wdata;
  logic        rw, cs;
  logic        req_valid, req_ready;
  logic [19:0] req_paddr;
  logic        resp_valid, resp_ready;
  logic        resp_hit, resp_multi, resp_stale;
  logic [15:0] resp_cpuaddr;

  always #5 clk = ~clk;

  mapper_revlookup dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cpuaddr_i      (cpuaddr),
    .wdata_i        (wdata),
    .rw_i           (rw),
    .cs_i           (cs),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_paddr_i    (req_paddr),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_hit_o     (resp_hit),
    .resp_multi_o   (resp_multi),
    .resp_stale_o   (resp_stale),
    .resp_cpuaddr_o (resp_cpuaddr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: shadow map, the values seen by each scan step, and the request's progress.
  logic [7:0]  m_shadow [16];
  logic [7:0]  m_seen   [16];
  logic [19:0] m_paddr;
  logic [3:0]  m_win;
  bit          m_busy, m_valid, m_stale, m_hit, m_multi;
  int          m_cnt;
  bit          check_en = 1'b0;

  function automatic logic [7:0] dflt(input int i);
    return (i <= 10) ? 8'(i) : 8'(240 + i);
  endfunction

  always @(posedge clk) begin
    bit wr;
    int n;
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_shadow[i] = dflt(i);
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_stale = 1'b0;
      m_hit   = 1'b0;
      m_multi = 1'b0;
    end else begin
      wr = cs && !rw;
      if (!m_busy && !m_valid) begin
        if (req_valid) begin
          m_busy  = 1'b1;
          m_cnt   = 0;
          m_paddr = req_paddr;
          m_stale = wr;
        end
      end else if (m_busy) begin
        m_seen[m_cnt] = m_shadow[m_cnt];
        m_stale = m_stale | wr;
        m_cnt++;
        if (m_cnt == 16) begin
          m_busy  = 1'b0;
          m_valid = 1'b1;
          n = 0;
          for (int i = 15; i >= 0; i--) begin
            if (m_seen[i] == m_paddr[19:12]) begin
              n++;
              m_win = 4'(i);
            end
          end
          m_hit   = (n > 0);
          m_multi = (n > 1);
        end
      end else begin
        m_stale = m_stale | wr;
        if (resp_ready) m_valid = 1'b0;
      end
      if (wr) m_shadow[cpuaddr[3:0]] = wdata;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("req_ready", req_ready, !m_busy && !m_valid);
      chk("resp_valid", resp_valid, m_valid);
      if (m_valid) begin
        chk("resp_hit", resp_hit, m_hit);
        chk("resp_multi", resp_multi, m_multi);
        chk("resp_stale", resp_stale, m_stale);
        chk("resp_cpuaddr", resp_cpuaddr, m_hit ? {m_win, m_paddr[11:0]} : 16'h0000);
      end
    end
  end

  // Issue one lookup from IDLE; optionally inject a snoop write at scan step wr_at and
  // hold resp_ready low for `hold` cycles once the response appears.
  task automatic lookup(input logic [19:0] pa, input int wr_at, input logic [3:0] wa,
                        input logic [7:0] wd, input int hold, output int lat,
                        output logic o_hit, output logic o_multi, output logic o_stale,
                        output logic [15:0] o_cpu);
    req_valid = 1'b1;
    req_paddr = pa;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      if (lat == wr_at) begin
        cs = 1'b1; rw = 1'b0; cpuaddr = {12'h0, wa}; wdata = wd;
      end else begin
        cs = 1'b0; rw = 1'b1;
      end
      @(negedge clk);
      lat++;
    end
    cs = 1'b0; rw = 1'b1;
    if (!resp_valid) chk("response timeout", 32'(lat), 32'd16);
    o_hit = resp_hit; o_multi = resp_multi; o_stale = resp_stale; o_cpu = resp_cpuaddr;
    if (hold > 0) begin
      resp_ready = 1'b0;
      repeat (hold) @(negedge clk);
      chk("frozen valid", resp_valid, 1'b1);
      chk("frozen req_ready", req_ready, 1'b0);
      chk("frozen cpuaddr", resp_cpuaddr, o_cpu);
      chk("frozen hit", resp_hit, o_hit);
      chk("frozen multi", resp_multi, o_multi);
      resp_ready = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic snoop(input logic rd, input logic [3:0] a, input logic [7:0] d);
    cs = 1'b1; rw = rd; cpuaddr = {12'h0, a}; wdata = d;
    @(negedge clk);
    cs = 1'b0; rw = 1'b1;
  endtask

  function automatic logic [7:0] pick();
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return 8'($urandom);
    if (r == 1) return 8'($urandom_range(250, 255));
    return 8'($urandom_range(0, 5));
  endfunction

  initial begin
    int lat;
    logic h, m, s;
    logic [15:0] ca;

    rst_n = 1'b0; cs = 1'b0; rw = 1'b1; cpuaddr = '0; wdata = '0;
    req_valid = 1'b0; req_paddr = '0; resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_en = 1'b1;
    rst_n = 1'b1;
    chk("reset req_ready", req_ready, 1'b1);
    chk("reset resp_valid", resp_valid, 1'b0);
    chk("reset hit", resp_hit, 1'b0);
    chk("reset multi", resp_multi, 1'b0);
    chk("reset stale", resp_stale, 1'b0);
    chk("reset cpuaddr", resp_cpuaddr, 16'h0000);

    lookup(20'h05123, -1, 4'h0, 8'h00, 0, lat, h, m, s, ca);
    chk("latency", 32'(lat), 32'd16);
    chk("05123 hit", h, 1'b1);
    chk("05123 multi", m, 1'b0);
    chk("05123 stale", s, 1'b0);
    chk("05123 cpuaddr", ca, 16'h5123);
    chk("model 05123 cpuaddr", {m_win, m_paddr[11:0]}, 16'h5123);

    lookup(20'hFB456, -1, 4'h0, 8'h00, 0, lat, h, m, s, ca);
    chk("FB456 hit", h, 1'b1);
    chk("FB456 cpuaddr", ca, 16'hB456);
    lookup(20'h80000, -1, 4'h0, 8'h00, 0, lat, h, m, s, ca);
    chk("80000 hit", h, 1'b0);
    chk("80000 multi", m, 1'b0);
    chk("80000 cpuaddr", ca, 16'h0000);
    chk("model 80000 hit", m_hit, 1'b0);

    snoop(1'b1, 4'h3, 8'h77);
    lookup(20'h03000, -1, 4'h0, 8'h00, 0, lat, h, m, s, ca);
    chk("read ignored cpuaddr", ca, 16'h3000);
    chk("read ignored multi", m, 1'b0);

    snoop(1'b0, 4'h3, 8'h05);
    lookup(20'h05ABC, -1, 4'h0, 8'h00, 0, lat, h, m, s, ca);
    chk("dup hit", h, 1'b1);
    chk("dup multi", m, 1'b1);
    chk("dup cpuaddr", ca, 16'h3ABC);

    lookup(20'h40000, 4, 4'h0, 8'h40, 0, lat, h, m, s, ca);
    chk("stale run hit", h, 1'b0);
    chk("stale run stale", s, 1'b1);
    chk("stale run latency", 32'(lat), 32'd16);
    lookup(20'h40000, -1, 4'h0, 8'h00, 0, lat, h, m, s, ca);
    chk("repeat hit", h, 1'b1);
    chk("repeat cpuaddr", ca, 16'h0000);
    chk("repeat stale", s, 1'b0);

    lookup(20'h0A777, -1, 4'h0, 8'h00, 10, lat, h, m, s, ca);
    chk("backpressure cpuaddr", ca, 16'hA777);

    req_valid = 1'b1; req_paddr = 20'h07000;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort resp_valid", resp_valid, 1'b0);
    chk("abort req_ready", req_ready, 1'b1);
    lookup(20'h03000, -1, 4'h0, 8'h00, 0, lat, h, m, s, ca);
    chk("restored entry 3", ca, 16'h3000);
    chk("restored entry 3 multi", m, 1'b0);
    lookup(20'h40000, -1, 4'h0, 8'h00, 0, lat, h, m, s, ca);
    chk("restored entry 0", h, 1'b0);

    for (int c = 0; c < 4000; c++) begin
      rst_n      = ($urandom_range(0, 299) != 0);
      cs         = ($urandom_range(0, 3) == 0);
      rw         = 1'($urandom_range(0, 1));
      cpuaddr    = 16'($urandom);
      wdata      = pick();
      req_valid  = ($urandom_range(0, 2) == 0);
      req_paddr  = {pick(), 12'($urandom)};
      resp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1; cs = 1'b0; rw = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
